bsg_lru_pseudo_tree_tracker: RTL

Parametrised tree pseudo-LRU state keeper for a set-associative cache: holds `ways_p-1` PLRU node bits per set, applies MRU updates on hits, and returns a replacement victim per request with a 1-cycle registered response. Adds capabilities a plain way-to-update decoder lacks:
- per-way lock mask, with locked ways never chosen;
- optional allocate-and-touch on victim selection;
- same-cycle touch bypass;
- sequenced INIT/clear sweep.

Sits beside the tag array in the cache miss path.

---
 rtl/bsg_lru_pkg.sv | 23 ++
 rtl/bsg_lru_pseudo_tree_tracker_if.sv | 34 +++
 rtl/bsg_lru_pseudo_tree_select.sv | 42 ++++
 rtl/bsg_lru_pseudo_tree_tracker.sv | 130 +++++++++++++
 4 files changed

// File: rtl/bsg_lru_pkg.sv
// Shared types and heap-index helpers for the tree pseudo-LRU tracker.
// Heap order: node 0 is the root, children of n are 2n+1 (lower) and 2n+2 (upper).
package bsg_lru_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } lru_state_e;

    function automatic int lru_parent(input int node);
        return (node - 1) / 2;
    endfunction

    function automatic int lru_child(input int node, input logic upper);
        return upper ? (2 * node + 2) : (2 * node + 1);
    endfunction

    // Leaves sit after the ways-1 internal nodes, in way order.
    function automatic int lru_leaf_node(input int ways, input int way);
        return ways - 1 + way;
    endfunction

endpackage

// File: rtl/bsg_lru_pseudo_tree_tracker_if.sv
// Cache-side bundle for the PLRU tracker: clear, hit touch, victim request and response.
interface bsg_lru_pseudo_tree_tracker_if #(
    parameter int ways_p = 8,
    parameter int sets_p = 4
);
    localparam int lg_ways_lp = $clog2(ways_p);
    localparam int lg_sets_lp = $clog2(sets_p);

    logic                  clear_i;
    logic                  ready_o;
    logic                  touch_v_i;
    logic [lg_sets_lp-1:0] touch_set_i;
    logic [lg_ways_lp-1:0] touch_way_i;
    logic                  victim_v_i;
    logic [lg_sets_lp-1:0] victim_set_i;
    logic                  victim_alloc_i;
    logic [ways_p-1:0]     way_lock_i;
    logic                  victim_v_o;
    logic [lg_ways_lp-1:0] victim_way_o;
    logic                  victim_none_o;

    modport master (
        output clear_i, touch_v_i, touch_set_i, touch_way_i,
               victim_v_i, victim_set_i, victim_alloc_i, way_lock_i,
        input  ready_o, victim_v_o, victim_way_o, victim_none_o
    );

    modport slave (
        input  clear_i, touch_v_i, touch_set_i, touch_way_i,
               victim_v_i, victim_set_i, victim_alloc_i, way_lock_i,
        output ready_o, victim_v_o, victim_way_o, victim_none_o
    );

endinterface

// File: rtl/bsg_lru_pseudo_tree_select.sv
// Combinational lock-aware victim walk over one set's PLRU node bits.
// A node bit of 1 points at the upper subtree; a fully locked subtree is skipped.
module bsg_lru_pseudo_tree_select
    import bsg_lru_pkg::*;
#(
    parameter  int ways_p     = 8,
    localparam int lg_ways_lp = $clog2(ways_p),
    localparam int nodes_lp   = ways_p - 1
) (
    input  logic [nodes_lp-1:0]   nodes_i,
    input  logic [ways_p-1:0]     lock_i,
    output logic [lg_ways_lp-1:0] way_o,
    output logic                  none_o
);

    function automatic logic [lg_ways_lp:0] walk(input logic [nodes_lp-1:0] nodes,
                                                 input logic [ways_p-1:0]   lock);
        int               node = 0;
        int               lo   = 0;
        int               span = ways_p;
        logic [ways_p-1:0] half_mask;
        logic             lower_locked;
        logic             upper_locked;
        logic             go_upper;
        for (int lvl = 0; lvl < lg_ways_lp; lvl++) begin
            span         = span / 2;
            half_mask    = (ways_p'(1) << span) - ways_p'(1);
            lower_locked = ((lock >> lo) & half_mask) == half_mask;
            upper_locked = ((lock >> (lo + span)) & half_mask) == half_mask;
            go_upper     = (|(nodes & (nodes_lp'(1) << node))) ? !upper_locked : lower_locked;
            if (go_upper) lo = lo + span;
            node = lru_child(node, go_upper);
        end
        if (&lock) return {1'b1, {lg_ways_lp{1'b0}}};
        return {1'b0, lg_ways_lp'(lo)};
    endfunction

    always_comb begin
        {none_o, way_o} = walk(nodes_i, lock_i);
    end

endmodule

// File: rtl/bsg_lru_pseudo_tree_tracker.sv
// Per-set tree pseudo-LRU state with hit touches, lock-aware victim selection,
// optional allocate-and-touch, same-cycle touch bypass and a set-by-set clear sweep.
module bsg_lru_pseudo_tree_tracker
    import bsg_lru_pkg::*;
#(
    parameter int ways_p = 8,
    parameter int sets_p = 4
) (
    input logic                          clk_i,
    input logic                          reset_n_i,
    bsg_lru_pseudo_tree_tracker_if.slave bus
);

    localparam int lg_ways_lp = $clog2(ways_p);
    localparam int lg_sets_lp = $clog2(sets_p);
    localparam int nodes_lp   = ways_p - 1;

    typedef logic [nodes_lp-1:0] row_t;

    // Every node on the way's path is made to point away from that way.
    function automatic row_t touch_row(input row_t row, input logic [lg_ways_lp-1:0] way);
        row_t result = row;
        int   node   = lru_leaf_node(ways_p, int'(way));
        int   parent;
        row_t mask;
        for (int lvl = 0; lvl < lg_ways_lp; lvl++) begin
            parent = lru_parent(node);
            mask   = row_t'(1) << parent;
            if (node == lru_child(parent, 1'b0)) result = result | mask;
            else                                 result = result & ~mask;
            node = parent;
        end
        return result;
    endfunction

    lru_state_e            state_r, state_n;
    logic [lg_sets_lp-1:0] init_cnt_r, init_cnt_n;
    row_t                  plru_r [sets_p];

    logic                  accept_touch, accept_victim, do_alloc;
    row_t                  touched_row, victim_base, alloc_row;
    logic [lg_ways_lp-1:0] sel_way;
    logic                  sel_none;

    assign bus.ready_o   = (state_r == READY) && !bus.clear_i;
    assign accept_touch  = bus.ready_o && bus.touch_v_i;
    assign accept_victim = bus.ready_o && bus.victim_v_i;

    // The victim walk sees the external touch first when both hit the same set.
    assign touched_row = touch_row(plru_r[bus.touch_set_i], bus.touch_way_i);
    assign victim_base = (accept_touch && (bus.touch_set_i == bus.victim_set_i))
                         ? touched_row : plru_r[bus.victim_set_i];

    bsg_lru_pseudo_tree_select #(.ways_p(ways_p)) select (
        .nodes_i (victim_base),
        .lock_i  (bus.way_lock_i),
        .way_o   (sel_way),
        .none_o  (sel_none)
    );

    assign alloc_row = touch_row(victim_base, sel_way);
    assign do_alloc  = accept_victim && bus.victim_alloc_i && !sel_none;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r    <= INIT;
            init_cnt_r <= '0;
        end else begin
            state_r    <= state_n;
            init_cnt_r <= init_cnt_n;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_n    = state_r;
        init_cnt_n = init_cnt_r;
        case (state_r)
            INIT: begin
                if (bus.clear_i) begin
                    init_cnt_n = '0;
                end else if (init_cnt_r == lg_sets_lp'(sets_p - 1)) begin
                    state_n    = READY;
                    init_cnt_n = '0;
                end else begin
                    init_cnt_n = init_cnt_r + lg_sets_lp'(1);
                end
            end
            READY: begin
                if (bus.clear_i) begin
                    state_n    = INIT;
                    init_cnt_n = '0;
                end
            end
            default: begin
                state_n    = INIT;
                init_cnt_n = '0;
            end
        endcase
    end

    // NOTE: the node array has no reset term; the INIT sweep that follows
    // every reset clears it one set per cycle, keeping it a plain register file.
    always_ff @(posedge clk_i) begin
        if (state_r == INIT) begin
            plru_r[init_cnt_r] <= '0;
        end else begin
            if (accept_touch) plru_r[bus.touch_set_i]  <= touched_row;
            if (do_alloc)     plru_r[bus.victim_set_i] <= alloc_row;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            bus.victim_v_o    <= 1'b0;
            bus.victim_way_o  <= '0;
            bus.victim_none_o <= 1'b0;
        end else begin
            bus.victim_v_o <= accept_victim;
            if (accept_victim) begin
                bus.victim_way_o  <= sel_way;
                bus.victim_none_o <= sel_none;
            end
        end
    end

endmodule
